// File: rtl/elastic_pipe_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | elastic_pipe_reg: DEPTH-stage valid/ready pipeline with bubble        |
// | collapse, global stall, flush and occupancy count.                    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module elastic_pipe_reg #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             stall,
  input  logic             flush,
  output logic [CW-1:0]    occupancy
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [CW-1:0]    occ_q, occ_d;
  logic             run, accept, pop;

  assign run       = ~stall & ~flush;
  assign out_valid = run & valid_q[DEPTH-1];
  assign pop       = out_valid & out_ready;
  assign in_ready  = run & (~valid_q[0] | adv[0]);
  assign accept    = in_valid & in_ready;
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = occ_q;

  // A stage moves forward if the stage ahead is empty or itself moving out.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = pop;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i] = run & valid_q[i] & (~valid_q[i+1] | adv[i+1]);
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    occ_d   = occ_q;
    if (flush) begin
      valid_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i] = '0;
      end
      occ_d = '0;
    end else if (run) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (adv[i]) begin
          valid_d[i] = 1'b0;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i-1]) begin
          valid_d[i] = 1'b1;
          data_d[i]  = data_q[i-1];
        end
      end
      if (accept) begin
        valid_d[0] = 1'b1;
        data_d[0]  = in_data;
      end
      occ_d = occ_q + CW'(accept) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule
`default_nettype wire
